core_fetch: RTL and testbench
=============================

CORE_FETCH -- requirements
Module: core_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, address of the first instruction fetched after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Port: imem_req  output  1  fetch request, held high until imem_ack.
REQ-005 Port: imem_addr  output  16  fetch address; equals internal pc.
REQ-006 Port: imem_ack  input  1  data on imem_rdata is valid for imem_addr in this cycle.
REQ-007 Port: imem_rdata  input  16  instruction word.
REQ-008 Port: stall  input  1  downstream not ready; the issued instruction is held.
REQ-009 Port: redirect  input  1  taken branch or jump; the pipeline restarts at redirect_pc.
REQ-010 Port: redirect_pc  input  16  target address.
REQ-011 Port: halt  input  1  from the controller's decode of the issued instruction.
REQ-012 Port: inst_valid  output  1  inst, op fields and inst_pc are valid.
REQ-013 Port: inst  output  16  latched instruction word.
REQ-014 Port: op1 / op2 / op3  output  2 / 3 / 4  inst[15:14] / inst[13:11] / inst[7:4].
REQ-015 Port: inst_pc  output  16  address of inst.
REQ-016 Port: halted  output  1  core stopped.
REQ-017 Port: inst_count  output  16  count of consumed instructions.

Function
REQ-018 States: FETCH, ISSUE, HALTED, encoded as a registered state machine.
REQ-019 FETCH: imem_req=1, inst_valid=0; on imem_ack with no redirect, latch imem_rdata into inst, set inst_pc=pc and go to ISSUE next cycle.
REQ-020 ISSUE: imem_req=0, inst_valid=1; inst, op fields and inst_pc are stable while stall=1.
REQ-021 Consume: the instruction is consumed in any cycle where state is ISSUE and stall=0.
REQ-022 On consume with halt=1, go to HALTED; otherwise set pc=inst_pc+1 and go to FETCH.
REQ-023 Priority within ISSUE: redirect > halt > advance.
REQ-024 Redirect in ISSUE, regardless of stall: pc=redirect_pc, go to FETCH, inst_valid=0 next cycle, no consume and no count.
REQ-025 Redirect in FETCH: pc=redirect_pc next cycle, imem_req stays 1, and any imem_ack in the same cycle is discarded.
REQ-026 HALTED: imem_req=0, inst_valid=0, halted=1; redirect, stall and imem_ack are ignored; the only exit is reset.
REQ-027 halt is ignored when inst_valid=0 and when stall=1.
REQ-028 inst_count increments by 1 on every consume, including the consumed halt instruction, and wraps 16'hFFFF to 16'h0000.
REQ-029 pc increments modulo 2^16: 16'hFFFF+1 gives 16'h0000.
REQ-030 Minimum latency: ack cycle N gives inst_valid=1 in cycle N+1; consume in cycle M gives imem_req=1 for pc+1 in cycle M+1.
REQ-031 imem_ack outside FETCH is ignored.

Reset
REQ-032 While rst_n=0 at a clock edge, the next state is: state=FETCH, pc=RESET_PC, inst=0, inst_pc=0, inst_count=0, halted=0.
REQ-033 While rst_n=0: imem_req=0 and inst_valid=0; imem_req rises in the first cycle after rst_n returns high.
REQ-034 Reset in any state, including mid-fetch or HALTED, aborts the current operation without a consume or count.

Verification
REQ-035 Reset release, imem returns 16'hC000 in the first request cycle, stall=0 -> imem_addr=0000, inst_valid next cycle with op1=3, inst_pc=0000, next imem_addr=0001, inst_count=1.
REQ-036 Issue 16'hC0F0 (op1=3, op3=F), controller asserts halt, stall=0 -> halted=1, imem_req=0 thereafter, inst_count increments once, redirect ignored afterwards.
REQ-037 stall=1 for 3 cycles in ISSUE with inst=16'h8012 -> inst, op fields and inst_pc held constant, no fetch, inst_count unchanged until stall drops.
REQ-038 redirect=1 with redirect_pc=16'h0040 in the same cycle as imem_ack -> ack data discarded, next imem_addr=0040, inst_valid stays 0.
REQ-039 redirect in ISSUE with stall=1 -> next state FETCH at redirect_pc, inst_count unchanged.
REQ-040 RESET_PC=16'hFFFF, two instructions consumed -> second fetch address 0000; preload inst_count=FFFF then one consume -> inst_count=0000.

Source files
------------

// File: rtl/core_fetch.sv
// Instruction fetch stage for a 16-bit core.
// It requests a word from instruction memory, holds it for issue until it is consumed, and handles redirect and halt.
module core_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [1:0]  op1,
    output logic [2:0]  op2,
    output logic [3:0]  op3,
    output logic [15:0] inst_pc,
    output logic        halted,
    output logic [15:0] inst_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] inst_pc_q, inst_pc_d;
    logic [15:0] count_q, count_d;

    // A redirect outranks everything else, in both FETCH and ISSUE; halt only matters when the word is consumed.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        count_d   = count_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!stall) begin
                    count_d = count_q + 16'd1;
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d    = inst_pc_q + 16'd1;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= 16'h0000;
            inst_pc_q <= 16'h0000;
            count_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            count_q   <= count_d;
        end
    end

    // Gating with rst_n keeps the memory port and issue quiet for the whole time reset is held.
    assign imem_req   = rst_n && (state_q == FETCH);
    assign inst_valid = rst_n && (state_q == ISSUE);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign op1        = inst_q[15:14];
    assign op2        = inst_q[13:11];
    assign op3        = inst_q[7:4];
    assign inst_pc    = inst_pc_q;
    assign halted     = (state_q == HALTED);
    assign inst_count = count_q;

endmodule

// File: tb/tb_core_fetch.sv
// Self-checking bench for core_fetch: directed scenarios followed by random traffic.
// Every DUT output is compared each cycle against a transaction-level reference model.
module tb_core_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    logic        imem_req, inst_valid, halted;
    logic [15:0] imem_addr, inst, inst_pc, inst_count;
    logic [1:0]  op1;
    logic [2:0]  op2;
    logic [3:0]  op3;

    logic        imem_req1, inst_valid1, halted1;
    logic [15:0] imem_addr1, inst1, inst_pc1, inst_count1;
    logic [1:0]  op1_1;
    logic [2:0]  op2_1;
    logic [3:0]  op3_1;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: where the core is in its fetch/issue/halt life, plus the architectural values.
    int          mWhere;
    logic [15:0] mPc, mInst, mInstPc, mCount;

    core_fetch #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst(inst), .op1(op1), .op2(op2), .op3(op3),
        .inst_pc(inst_pc), .halted(halted), .inst_count(inst_count)
    );

    core_fetch #(.RESET_PC(16'hFFFF)) dutHigh (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid1), .inst(inst1), .op1(op1_1), .op2(op2_1), .op3(op3_1),
        .inst_pc(inst_pc1), .halted(halted1), .inst_count(inst_count1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ack, input logic [15:0] rdata,
                                 input logic stl, input logic redir, input logic [15:0] rpc,
                                 input logic hlt);
        rst_n       = r;
        imem_ack    = ack;
        imem_rdata  = rdata;
        stall       = stl;
        redirect    = redir;
        redirect_pc = rpc;
        halt        = hlt;
        #1;
    endtask

    task automatic modelReset();
        mWhere  = 0;
        mPc     = 16'h0000;
        mInst   = 16'h0000;
        mInstPc = 16'h0000;
        mCount  = 16'h0000;
    endtask

    task automatic compareAll();
        checkOutput("imem_req",   {15'd0, imem_req},   {15'd0, rst_n && mWhere == 0});
        checkOutput("inst_valid", {15'd0, inst_valid}, {15'd0, rst_n && mWhere == 1});
        checkOutput("halted",     {15'd0, halted},     {15'd0, mWhere == 2});
        checkOutput("imem_addr",  imem_addr,  mPc);
        checkOutput("inst",       inst,       mInst);
        checkOutput("op1",        {14'd0, op1}, {14'd0, mInst >> 14});
        checkOutput("op2",        {13'd0, op2}, {13'd0, (mInst >> 11) & 16'h7});
        checkOutput("op3",        {12'd0, op3}, {12'd0, (mInst >> 4) & 16'hF});
        checkOutput("inst_pc",    inst_pc,    mInstPc);
        checkOutput("inst_count", inst_count, mCount);
    endtask

    // One transaction-level step: a word is accepted, consumed, retargeted, or nothing happens.
    task automatic modelStep();
        bit accepted, consumed, retarget;
        if (!rst_n) begin
            modelReset();
            return;
        end
        retarget = redirect && mWhere != 2;
        accepted = mWhere == 0 && imem_ack && !redirect;
        consumed = mWhere == 1 && !stall && !redirect;
        if (retarget) begin
            mPc    = redirect_pc;
            mWhere = 0;
        end
        if (accepted) begin
            mInst   = imem_rdata;
            mInstPc = mPc;
            mWhere  = 1;
        end
        if (consumed) begin
            mCount = mCount + 16'd1;
            if (halt) begin
                mWhere = 2;
            end else begin
                mPc    = mInstPc + 16'd1;
                mWhere = 0;
            end
        end
    endtask

    task automatic stepCycle();
        #1;
        compareAll();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        modelReset();
        stepCycle();
        checkOutput("rst_req_low", {15'd0, imem_req}, 16'h0000);
        checkOutput("high_reset_addr", imem_addr1, 16'hFFFF);

        // First fetch after reset release, then a straight consume.
        applyStimulus(1'b1, 1'b1, 16'hC000, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("first_req", {15'd0, imem_req}, 16'h0001);
        checkOutput("first_addr", imem_addr, 16'h0000);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("first_valid", {15'd0, inst_valid}, 16'h0001);
        checkOutput("first_op1", {14'd0, op1}, 16'h0003);
        checkOutput("first_inst_pc", inst_pc, 16'h0000);
        stepCycle();
        checkOutput("next_addr", imem_addr, 16'h0001);
        checkOutput("count_one", inst_count, 16'h0001);
        checkOutput("high_wrap_addr", imem_addr1, 16'h0000);
        checkOutput("high_count", inst_count1, 16'h0001);

        // Stall holds the issued word.
        applyStimulus(1'b1, 1'b1, 16'h8012, 1'b0, 1'b0, 16'h0, 1'b0);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0, 1'b1);
            checkOutput("stall_inst", inst, 16'h8012);
            checkOutput("stall_inst_pc", inst_pc, 16'h0001);
            checkOutput("stall_no_req", {15'd0, imem_req}, 16'h0000);
            checkOutput("stall_count", inst_count, 16'h0001);
            stepCycle();
        end
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        stepCycle();
        checkOutput("stall_release_count", inst_count, 16'h0002);

        // Redirect in the same cycle as an ack discards the returned word.
        applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0040, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("redir_fetch_addr", imem_addr, 16'h0040);
        checkOutput("redir_fetch_valid", {15'd0, inst_valid}, 16'h0000);
        stepCycle();

        // Redirect during a stalled issue.
        applyStimulus(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0080, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("redir_issue_addr", imem_addr, 16'h0080);
        checkOutput("redir_issue_req", {15'd0, imem_req}, 16'h0001);
        checkOutput("redir_issue_count", inst_count, 16'h0002);

        // Instruction counter wraps from FFFF to 0000.
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        mCount = 16'hFFFF;
        applyStimulus(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        stepCycle();
        checkOutput("count_wrap", inst_count, 16'h0000);

        // Halt on consume; afterwards redirect and ack are ignored.
        applyStimulus(1'b1, 1'b1, 16'hC0F0, 1'b0, 1'b0, 16'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("halt_op3", {12'd0, op3}, 16'h000F);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h2222, 1'b0, 1'b1, 16'h0300, 1'b0);
            checkOutput("halted_flag", {15'd0, halted}, 16'h0001);
            checkOutput("halted_req", {15'd0, imem_req}, 16'h0000);
            checkOutput("halted_count", inst_count, 16'h0001);
            stepCycle();
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 40) != 0,
                          $urandom_range(0, 1) == 0,
                          16'($urandom),
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0,
                          16'($urandom),
                          $urandom_range(0, 15) == 0);
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
